// File: rtl/ib_pkg.sv
// ----------------------------------------------------------------------------
// ib_pkg
//   Shared definitions for the fetch-to-decode instruction queue.
//   - Default geometry constants (depth, fetch/issue widths, exception code
//     width) used as parameter defaults by inst_queue and ib_compact.
//   - ib_entry_t: one queued instruction with its branch-prediction and
//     fetch-exception side information. The queue never interprets these
//     fields; it only stores and replays them in order.
// ----------------------------------------------------------------------------
package ib_pkg;

    localparam int unsigned IB_DEPTH   = 16;
    localparam int unsigned IB_FETCH_W = 2;
    localparam int unsigned IB_ISSUE_W = 2;
    localparam int unsigned IB_ECODE_W = 6;

    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           inst;
        logic                  ptaken;
        logic [31:0]           paddr;
        logic                  excp;
        logic [IB_ECODE_W-1:0] ecode;
    } ib_entry_t;

endpackage

// File: rtl/ib_compact.sv
// ----------------------------------------------------------------------------
// ib_compact
//   Combinational prefix-popcount over the fetch valid mask. Each valid slot
//   is assigned a write offset equal to the number of valid slots below it,
//   so the valid slots land in consecutive queue entries in slot order even
//   when the mask has holes (e.g. 2'b10 stores slot 1 at offset 0).
// Ports
//   valid   in   FETCH_W          per-slot valid, slot 0 oldest
//   offset  out  FETCH_W x OFF_W  write offset of each slot from the tail
//   npush   out  OFF_W            number of valid slots
// ----------------------------------------------------------------------------
module ib_compact
    import ib_pkg::*;
#(
    parameter int unsigned FETCH_W = IB_FETCH_W,
    parameter int unsigned OFF_W   = $clog2(FETCH_W + 1)
) (
    input  logic [FETCH_W-1:0]            valid,
    output logic [FETCH_W-1:0][OFF_W-1:0] offset,
    output logic [OFF_W-1:0]              npush
);

    logic [OFF_W-1:0] acc;

    always_comb begin
        acc    = '0;
        offset = '0;
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            offset[i] = acc;
            acc       = acc + OFF_W'(valid[i]);
        end
        npush = acc;
    end

endmodule

// File: rtl/inst_queue.sv
// ----------------------------------------------------------------------------
// inst_queue
//   Fetch-to-decode instruction queue built on one circular buffer of DEPTH
//   entries. Up to FETCH_W instructions are written per cycle (valid slots
//   compacted in slot order); the oldest ISSUE_W entries are presented
//   combinationally to decode, which pops 0..ISSUE_W of them per cycle.
// Ports
//   clk, rst          clock; synchronous active-high reset
//   flush             discard all entries (redirect), next cycle empty
//   push_valid        per-slot valid, slot 0 oldest
//   push_pc/inst/ptaken/paddr/excp/ecode   per-slot payload (packed, slot i
//                     at bits [i*W +: W])
//   push_ready        free entries >= FETCH_W (depends on count only)
//   out_valid         head entry i present (i < count)
//   out_pc/inst/ptaken/paddr/excp/ecode    head entries, index 0 oldest
//   pop_cnt           entries consumed this cycle
//   count             current occupancy
//   empty, full       count == 0, count == DEPTH
// Notes
//   The storage array has no reset; occupancy alone determines visibility.
//   Pushed data is visible the cycle after the push; there is no bypass.
//   The ecode field width comes from ib_pkg, so ECODE_W must match it.
// ----------------------------------------------------------------------------
module inst_queue
    import ib_pkg::*;
#(
    parameter int unsigned DEPTH   = IB_DEPTH,
    parameter int unsigned FETCH_W = IB_FETCH_W,
    parameter int unsigned ISSUE_W = IB_ISSUE_W,
    parameter int unsigned ECODE_W = IB_ECODE_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,

    input  logic [FETCH_W-1:0]            push_valid,
    input  logic [FETCH_W*32-1:0]         push_pc,
    input  logic [FETCH_W*32-1:0]         push_inst,
    input  logic [FETCH_W-1:0]            push_ptaken,
    input  logic [FETCH_W*32-1:0]         push_paddr,
    input  logic [FETCH_W-1:0]            push_excp,
    input  logic [FETCH_W*ECODE_W-1:0]    push_ecode,
    output logic                          push_ready,

    output logic [ISSUE_W-1:0]            out_valid,
    output logic [ISSUE_W*32-1:0]         out_pc,
    output logic [ISSUE_W*32-1:0]         out_inst,
    output logic [ISSUE_W-1:0]            out_ptaken,
    output logic [ISSUE_W*32-1:0]         out_paddr,
    output logic [ISSUE_W-1:0]            out_excp,
    output logic [ISSUE_W*ECODE_W-1:0]    out_ecode,
    input  logic [$clog2(ISSUE_W+1)-1:0]  pop_cnt,

    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          empty,
    output logic                          full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned POP_W = $clog2(ISSUE_W + 1);
    localparam int unsigned OFF_W = $clog2(FETCH_W + 1);

    ib_entry_t                     mem [DEPTH];
    logic [PTR_W-1:0]              head;
    logic [PTR_W-1:0]              tail;

    logic [FETCH_W-1:0][OFF_W-1:0] wr_off;
    logic [OFF_W-1:0]              npush;
    logic [OFF_W-1:0]              npush_eff;
    logic [POP_W-1:0]              npop;
    logic                          push_fire;

    ib_entry_t                     push_entry [FETCH_W];
    logic [PTR_W-1:0]              wr_idx     [FETCH_W];
    logic [PTR_W-1:0]              rd_idx     [ISSUE_W];

    // ------------------------------------------------------------------
    // Slot compaction
    // ------------------------------------------------------------------
    ib_compact #(
        .FETCH_W (FETCH_W),
        .OFF_W   (OFF_W)
    ) u_compact (
        .valid  (push_valid),
        .offset (wr_off),
        .npush  (npush)
    );

    // ------------------------------------------------------------------
    // Handshake and occupancy status
    // ------------------------------------------------------------------
    always_comb begin
        push_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_W);
        push_fire  = push_ready && (|push_valid);
        npush_eff  = push_fire ? npush : '0;
        empty      = (count == '0);
        full       = (count == CNT_W'(DEPTH));
    end

    // Pop amount is clamped to the occupancy so an illegal request can
    // never drive count negative.
    always_comb begin
        if (CNT_W'(pop_cnt) > count) begin
            npop = POP_W'(count);
        end else begin
            npop = pop_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Write path: unpack slots, compute wrapped destination entries
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            push_entry[i].pc     = push_pc[i*32 +: 32];
            push_entry[i].inst   = push_inst[i*32 +: 32];
            push_entry[i].ptaken = push_ptaken[i];
            push_entry[i].paddr  = push_paddr[i*32 +: 32];
            push_entry[i].excp   = push_excp[i];
            push_entry[i].ecode  = push_ecode[i*ECODE_W +: ECODE_W];
            // Pointer width truncation provides the modulo-DEPTH wrap, so a
            // pair written at DEPTH-1 splits across DEPTH-1 and 0.
            wr_idx[i]            = tail + PTR_W'(wr_off[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire && !flush && !rst) begin
            for (int unsigned i = 0; i < FETCH_W; i++) begin
                if (push_valid[i]) begin
                    mem[wr_idx[i]] <= push_entry[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointers and count
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(npop);
            tail  <= tail + PTR_W'(npush_eff);
            count <= count + CNT_W'(npush_eff) - CNT_W'(npop);
        end
    end

    // ------------------------------------------------------------------
    // Read path: oldest ISSUE_W entries, straight from the array
    // ------------------------------------------------------------------
    always_comb begin
        out_valid  = '0;
        out_pc     = '0;
        out_inst   = '0;
        out_ptaken = '0;
        out_paddr  = '0;
        out_excp   = '0;
        out_ecode  = '0;
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            rd_idx[i]                    = head + PTR_W'(i);
            out_valid[i]                 = CNT_W'(i) < count;
            out_pc[i*32 +: 32]           = mem[rd_idx[i]].pc;
            out_inst[i*32 +: 32]         = mem[rd_idx[i]].inst;
            out_ptaken[i]                = mem[rd_idx[i]].ptaken;
            out_paddr[i*32 +: 32]        = mem[rd_idx[i]].paddr;
            out_excp[i]                  = mem[rd_idx[i]].excp;
            out_ecode[i*ECODE_W +: ECODE_W] = mem[rd_idx[i]].ecode;
        end
    end

    // Decode may only consume entries it is actually shown.
    pop_legal: assert property (@(posedge clk) disable iff (rst)
        (32'(pop_cnt) <= ISSUE_W) && (CNT_W'(pop_cnt) <= count));

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  push_valid;
    logic [63:0] push_pc;
    logic [63:0] push_inst;
    logic [1:0]  push_ptaken;
    logic [63:0] push_paddr;
    logic [1:0]  push_excp;
    logic [11:0] push_ecode;
    logic        push_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_pc;
    logic [63:0] out_inst;
    logic [1:0]  out_ptaken;
    logic [63:0] out_paddr;
    logic [1:0]  out_excp;
    logic [11:0] out_ecode;
    logic [1:0]  pop_cnt;
    logic [4:0]  count;
    logic        empty;
    logic        full;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] sb[$];
    int unsigned mtail = 0;

    inst_queue #(
        .DEPTH   (16),
        .FETCH_W (2),
        .ISSUE_W (2),
        .ECODE_W (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .push_valid  (push_valid),
        .push_pc     (push_pc),
        .push_inst   (push_inst),
        .push_ptaken (push_ptaken),
        .push_paddr  (push_paddr),
        .push_excp   (push_excp),
        .push_ecode  (push_ecode),
        .push_ready  (push_ready),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_ptaken  (out_ptaken),
        .out_paddr   (out_paddr),
        .out_excp    (out_excp),
        .out_ecode   (out_ecode),
        .pop_cnt     (pop_cnt),
        .count       (count),
        .empty       (empty),
        .full        (full)
    );

    always #5 clk = ~clk;

    // Payload fields are derived from the PC so the scoreboard only needs PCs.
    function automatic logic [31:0] f_inst(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [1:0] exp_ov();
        return {sb.size() > 1, sb.size() > 0};
    endfunction

    task automatic set_push(input logic [1:0] m, input logic [31:0] pc0, input logic [31:0] pc1);
        push_valid  = m;
        push_pc     = {pc1, pc0};
        push_inst   = {f_inst(pc1), f_inst(pc0)};
        push_ptaken = {pc1[2], pc0[2]};
        push_paddr  = {pc1 + 32'h40, pc0 + 32'h40};
        push_excp   = {pc1[3], pc0[3]};
        push_ecode  = {pc1[9:4], pc0[9:4]};
    endtask

    task automatic idle();
        push_valid = 2'b00;
        pop_cnt    = 2'd0;
        flush      = 1'b0;
    endtask

    // One clock: reference model decides acceptance from its own occupancy,
    // then the scoreboard is updated at the edge.
    task automatic tick();
        int unsigned n     = sb.size();
        bit          ready = (16 - n) >= 2;
        bit          fire  = ready && (push_valid != 2'b00);
        int unsigned np    = (int'(pop_cnt) > n) ? n : int'(pop_cnt);
        logic [1:0]  m     = push_valid;
        logic [63:0] pcs   = push_pc;
        bit          fl    = flush;
        bit          rs    = rst;
        @(posedge clk);
        if (rs || fl) begin
            sb.delete();
            mtail = 0;
        end else begin
            repeat (np) void'(sb.pop_front());
            if (fire) begin
                for (int s = 0; s < 2; s++) begin
                    if (m[s]) begin
                        sb.push_back(pcs[s*32 +: 32]);
                        mtail = (mtail + 1) % 16;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        set_push(2'b00, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", push_ready); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid got %b exp 00", out_valid); end
    endtask

    task automatic test_push_pair();
        set_push(2'b11, 32'h1c00_0000, 32'h1c00_0004);
        tick();
        idle();
        checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL pair_out_valid got %b exp 11", out_valid); end
        checks++; if (count !== 5'd2) begin errors++; $display("FAIL pair_count got %0d exp 2", count); end
        checks++; if (out_pc[31:0] !== 32'h1c00_0000) begin errors++; $display("FAIL pair_pc0 got %h exp 1c000000", out_pc[31:0]); end
        checks++; if (out_pc[63:32] !== sb[1]) begin errors++; $display("FAIL pair_pc1 got %h exp %h", out_pc[63:32], sb[1]); end
        checks++; if (out_inst[31:0] !== f_inst(sb[0])) begin errors++; $display("FAIL pair_inst0 got %h exp %h", out_inst[31:0], f_inst(sb[0])); end
        checks++; if (out_paddr[63:32] !== sb[1] + 32'h40) begin errors++; $display("FAIL pair_paddr1 got %h exp %h", out_paddr[63:32], sb[1] + 32'h40); end
        checks++; if (out_ptaken !== {sb[1][2], sb[0][2]}) begin errors++; $display("FAIL pair_ptaken got %b exp %b", out_ptaken, {sb[1][2], sb[0][2]}); end
        checks++; if (out_ecode[11:6] !== sb[1][9:4]) begin errors++; $display("FAIL pair_ecode1 got %h exp %h", out_ecode[11:6], sb[1][9:4]); end
        pop_cnt = 2'd2;
        tick();
        idle();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pair_drain_empty got %b exp 1", empty); end
    endtask

    task automatic test_sparse_mask();
        set_push(2'b10, 32'hDEAD_0000, 32'h0000_0104);
        tick();
        idle();
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL sparse_count got %0d exp 1", count); end
        checks++; if (out_valid !== 2'b01) begin errors++; $display("FAIL sparse_out_valid got %b exp 01", out_valid); end
        checks++; if (out_pc[31:0] !== 32'h0000_0104) begin errors++; $display("FAIL sparse_pc0 got %h exp 00000104", out_pc[31:0]); end
        checks++; if (out_excp[0] !== 1'b0) begin errors++; $display("FAIL sparse_excp0 got %b exp 0", out_excp[0]); end
        pop_cnt = 2'd1;
        tick();
        idle();
    endtask

    task automatic test_fill();
        for (int k = 0; k < 7; k++) begin
            set_push(2'b11, 32'h2000_0000 + k*8, 32'h2000_0004 + k*8);
            tick();
        end
        idle();
        checks++; if (count !== 5'd14) begin errors++; $display("FAIL fill14_count got %0d exp 14", count); end
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL fill14_ready got %b exp 1", push_ready); end
        set_push(2'b01, 32'h2000_0038, 32'h2000_003C);
        tick();
        checks++; if (count !== 5'd15) begin errors++; $display("FAIL fill15_count got %0d exp 15", count); end
        checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL fill15_ready got %b exp 0", push_ready); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill15_full got %b exp 0", full); end
        // held push while not ready, then a pop in the same cycle: still blocked
        set_push(2'b11, 32'h0000_BAD0, 32'h0000_BAD4);
        tick();
        tick();
        checks++; if (count !== 5'(sb.size())) begin errors++; $display("FAIL blocked_count got %0d exp %0d", count, sb.size()); end
        pop_cnt = 2'd1;
        tick();
        pop_cnt = 2'd0;
        checks++; if (count !== 5'd14) begin errors++; $display("FAIL popfree_count got %0d exp 14", count); end
        tick();
        idle();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill16_full got %b exp 1", full); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill16_count got %0d exp 16", count); end
        for (int it = 0; it < 20 && sb.size() > 0; it++) begin
            checks++; if (out_pc[31:0] !== sb[0]) begin errors++; $display("FAIL fill_drain_pc0 got %h exp %h", out_pc[31:0], sb[0]); end
            if (sb.size() > 1) begin
                checks++; if (out_pc[63:32] !== sb[1]) begin errors++; $display("FAIL fill_drain_pc1 got %h exp %h", out_pc[63:32], sb[1]); end
            end
            pop_cnt = (sb.size() > 1) ? 2'd2 : 2'd1;
            tick();
        end
        idle();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL fill_drain_count got %0d exp 0", count); end
    endtask

    task automatic test_push_pop_same();
        set_push(2'b11, 32'h3000, 32'h3004);
        tick();
        set_push(2'b11, 32'h3008, 32'h300C);
        tick();
        idle();
        checks++; if (count !== 5'd4) begin errors++; $display("FAIL pp_count4 got %0d exp 4", count); end
        set_push(2'b11, 32'h3010, 32'h3014);
        pop_cnt = 2'd1;
        tick();
        idle();
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL pp_count5 got %0d exp 5", count); end
        checks++; if (out_pc[31:0] !== 32'h3004) begin errors++; $display("FAIL pp_head0 got %h exp 00003004", out_pc[31:0]); end
        checks++; if (out_pc[63:32] !== 32'h3008) begin errors++; $display("FAIL pp_head1 got %h exp 00003008", out_pc[63:32]); end
        for (int it = 0; it < 10 && sb.size() > 0; it++) begin
            checks++; if (out_pc[31:0] !== sb[0]) begin errors++; $display("FAIL pp_drain_pc0 got %h exp %h", out_pc[31:0], sb[0]); end
            pop_cnt = 2'd1;
            tick();
        end
        idle();
    endtask

    task automatic test_wrap();
        logic [31:0] npc = 32'h4000_0000;
        logic [1:0]  m;
        int unsigned maxp;
        // walk the tail to the last entry so the next pair straddles the wrap
        for (int it = 0; it < 40 && mtail != 15; it++) begin
            set_push(2'b01, npc, npc + 4);
            npc += 8;
            pop_cnt = (sb.size() > 0) ? 2'd1 : 2'd0;
            tick();
        end
        idle();
        set_push(2'b11, npc, npc + 4);
        npc += 8;
        tick();
        idle();
        for (int c = 0; c < 40; c++) begin
            checks++; if (count !== 5'(sb.size())) begin errors++; $display("FAIL wrap_count got %0d exp %0d", count, sb.size()); end
            checks++; if (out_valid !== exp_ov()) begin errors++; $display("FAIL wrap_out_valid got %b exp %b", out_valid, exp_ov()); end
            checks++; if (push_ready !== ((16 - sb.size()) >= 2)) begin errors++; $display("FAIL wrap_ready got %b exp %b", push_ready, (16 - sb.size()) >= 2); end
            if (sb.size() > 0) begin
                checks++; if (out_pc[31:0] !== sb[0]) begin errors++; $display("FAIL wrap_pc0 got %h exp %h", out_pc[31:0], sb[0]); end
                checks++; if (out_inst[31:0] !== f_inst(sb[0])) begin errors++; $display("FAIL wrap_inst0 got %h exp %h", out_inst[31:0], f_inst(sb[0])); end
            end
            if (sb.size() > 1) begin
                checks++; if (out_pc[63:32] !== sb[1]) begin errors++; $display("FAIL wrap_pc1 got %h exp %h", out_pc[63:32], sb[1]); end
                checks++; if (out_ecode[11:6] !== sb[1][9:4]) begin errors++; $display("FAIL wrap_ecode1 got %h exp %h", out_ecode[11:6], sb[1][9:4]); end
            end
            m = 2'($urandom_range(3, 0));
            set_push(m, npc, npc + 4);
            npc += 8;
            maxp = (sb.size() > 2) ? 2 : sb.size();
            pop_cnt = 2'($urandom_range(maxp, 0));
            tick();
        end
        idle();
        for (int it = 0; it < 20 && sb.size() > 0; it++) begin
            checks++; if (out_pc[31:0] !== sb[0]) begin errors++; $display("FAIL wrap_drain_pc0 got %h exp %h", out_pc[31:0], sb[0]); end
            pop_cnt = (sb.size() > 1) ? 2'd2 : 2'd1;
            tick();
        end
        idle();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_drain_empty got %b exp 1", empty); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            set_push(2'b11, 32'h5000 + k*8, 32'h5004 + k*8);
            tick();
        end
        set_push(2'b01, 32'h5018, 32'h501C);
        tick();
        idle();
        checks++; if (count !== 5'd7) begin errors++; $display("FAIL flush_pre_count got %0d exp 7", count); end
        set_push(2'b11, 32'h5100, 32'h5104);
        pop_cnt = 2'd2;
        flush   = 1'b1;
        tick();
        idle();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b exp 1", empty); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL flush_out_valid got %b exp 00", out_valid); end
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", push_ready); end
        set_push(2'b01, 32'h6000, 32'h6004);
        tick();
        idle();
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL postflush_count got %0d exp 1", count); end
        checks++; if (out_valid !== 2'b01) begin errors++; $display("FAIL postflush_out_valid got %b exp 01", out_valid); end
        checks++; if (out_pc[31:0] !== 32'h6000) begin errors++; $display("FAIL postflush_pc0 got %h exp 00006000", out_pc[31:0]); end
        pop_cnt = 2'd1;
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        set_push(2'b11, 32'h7000, 32'h7004);
        tick();
        set_push(2'b11, 32'h7008, 32'h700C);
        tick();
        rst     = 1'b1;
        pop_cnt = 2'd1;
        tick();
        rst = 1'b0;
        idle();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", count); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL midrst_out_valid got %b exp 00", out_valid); end
        set_push(2'b10, 32'h7100, 32'h7104);
        tick();
        idle();
        checks++; if (out_pc[31:0] !== 32'h7104) begin errors++; $display("FAIL midrst_pc0 got %h exp 00007104", out_pc[31:0]); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL midrst_next_count got %0d exp 1", count); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        set_push(2'b00, 32'h0, 32'h0);
        test_reset();
        test_push_pair();
        test_sparse_mask();
        test_fill();
        test_push_pop_same();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
